// File: rtl/binaryzation_frame_ctrl_if.sv
// Handshake bundle between the pixel source / host and the binaryzation frame
// controller. The master side is the source, host and binaryzation return path;
// the slave side is the frame controller itself.
interface binaryzation_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_i;
    logic                  abort_i;
    logic [DATA_WIDTH-1:0] threshold_cfg_i;
    logic                  src_valid_i;
    logic [DATA_WIDTH-1:0] src_data_i;
    logic                  src_ready_o;
    logic                  pixel_datav_o;
    logic [DATA_WIDTH-1:0] pixel_data_o;
    logic [DATA_WIDTH-1:0] threshold_o;
    logic                  binaryzation_datav_i;
    logic                  busy_o;
    logic                  frame_done_o;
    logic                  timeout_o;
    logic [15:0]           frame_cnt_o;

    modport master (
        output start_i, abort_i, threshold_cfg_i, src_valid_i, src_data_i,
               binaryzation_datav_i,
        input  src_ready_o, pixel_datav_o, pixel_data_o, threshold_o,
               busy_o, frame_done_o, timeout_o, frame_cnt_o
    );

    modport slave (
        input  start_i, abort_i, threshold_cfg_i, src_valid_i, src_data_i,
               binaryzation_datav_i,
        output src_ready_o, pixel_datav_o, pixel_data_o, threshold_o,
               busy_o, frame_done_o, timeout_o, frame_cnt_o
    );
endinterface

// File: rtl/binaryzation_frame_ctrl.sv
// Frame sequencer in front of the binaryzation datapath. Gates exactly
// IMAGE_WIDTH*IMAGE_HEIGHT pixels per frame, holds the threshold for the whole
// frame and counts returned binaryzation beats to detect frame completion.
// Optional feature: define BINZ_DRAIN_TIMEOUT_EN to abandon a frame whose
// binaryzation output stalls for DRAIN_TIMEOUT cycles while draining.
module binaryzation_frame_ctrl #(
    parameter int IMAGE_WIDTH   = 276,
    parameter int IMAGE_HEIGHT  = 276,
    parameter int DATA_WIDTH    = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input logic                     clk_i,
    input logic                     rst_n_i,
    binaryzation_frame_ctrl_if.slave bus
);
    localparam logic [31:0] N = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [31:0]           in_cnt_q, out_cnt_q, out_cnt_d;
    logic [DATA_WIDTH-1:0] threshold_q, pixel_data_q;
    logic                  pixel_datav_q;
    logic [15:0]           frame_cnt_q;
    logic                  src_ready, accept, start_ok, out_inc, last_in;
    logic                  timeout_fire;

    // Handshake decode: ready comes straight from the state register, abort kills the beat
    always_comb begin
        src_ready = (state_q == RUN);
        accept    = bus.src_valid_i & src_ready & ~bus.abort_i;
        start_ok  = (state_q == IDLE) & bus.start_i & ~bus.abort_i;
        out_inc   = bus.binaryzation_datav_i & ((state_q == RUN) | (state_q == DRAIN))
                    & (out_cnt_q != N);
        out_cnt_d = out_cnt_q + {31'd0, out_inc};
        last_in   = accept & (in_cnt_q == N - 32'd1);
    end

`ifdef BINZ_DRAIN_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    logic        timeout_q;

    // Idle counter only runs while draining and restarts on every returned beat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idle_cnt_q <= '0;
        end else if (state_q != DRAIN || bus.binaryzation_datav_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end

    // A frame that completes on the same edge is not treated as a timeout
    always_comb begin
        timeout_fire = (state_q == DRAIN) & ~bus.binaryzation_datav_i & ~bus.abort_i
                       & (idle_cnt_q + 32'd1 == 32'(DRAIN_TIMEOUT)) & (out_cnt_d != N);
    end

    // Sticky timeout flag, cleared only by the next accepted start
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timeout_q <= 1'b0;
        end else if (start_ok) begin
            timeout_q <= 1'b0;
        end else if (timeout_fire) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    logic unused_drain_timeout;

    assign unused_drain_timeout = |32'(DRAIN_TIMEOUT);
    assign timeout_fire         = 1'b0;
    assign bus.timeout_o        = 1'b0;
`endif

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (last_in) state_d = (out_cnt_d == N) ? DONE : DRAIN;
            DRAIN: begin
                if (out_cnt_d == N) begin
                    state_d = DONE;
                end else if (timeout_fire) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort_i) begin
            state_d = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Input/output beat counters restart with each accepted start
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (start_ok) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (accept) begin
                in_cnt_q <= in_cnt_q + 32'd1;
            end
            out_cnt_q <= out_cnt_d;
        end
    end

    // Threshold is captured once per frame so mid-frame host changes cannot leak in
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            threshold_q <= '0;
        end else if (start_ok) begin
            threshold_q <= bus.threshold_cfg_i;
        end
    end

    // Registered pixel forward; bubbles and rejected beats appear as zero gaps
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pixel_datav_q <= 1'b0;
            pixel_data_q  <= '0;
        end else begin
            pixel_datav_q <= accept;
            pixel_data_q  <= accept ? bus.src_data_i : '0;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt_q <= '0;
        end else if (state_q == DONE && !bus.abort_i) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.src_ready_o   = src_ready;
    assign bus.pixel_datav_o = pixel_datav_q;
    assign bus.pixel_data_o  = pixel_data_q;
    assign bus.threshold_o   = threshold_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.frame_done_o  = (state_q == DONE) & ~bus.abort_i;
    assign bus.frame_cnt_o   = frame_cnt_q;
endmodule

// File: tb/tb_binaryzation_frame_ctrl.sv
// Randomised scoreboard bench for binaryzation_frame_ctrl on a 4x2 frame.
// The driver pushes every accepted pixel and every expected frame completion into
// queues; an independent monitor pops and compares as the DUT presents them.
module tb_binaryzation_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int DT = 16;

    logic clk;
    logic rst_n;

    binaryzation_frame_ctrl_if #(.DATA_WIDTH(8)) bif ();

    binaryzation_frame_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .DATA_WIDTH   (8),
        .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bif)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_px[$];
    logic [15:0] exp_done[$];
    logic [7:0]  exp_thr = 8'd0;
    logic [15:0] exp_frames = 16'd0;
    int          done_seen = 0;
    int          bz_sent = 0;
    int          bz_base = 0;
    int          bz_limit = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Binaryzation stand-in: one-cycle echo of each forwarded pixel, up to a per-frame limit
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bif.binaryzation_datav_i <= 1'b0;
        end else if (bif.pixel_datav_o && (bz_sent - bz_base < bz_limit)) begin
            bif.binaryzation_datav_i <= 1'b1;
            bz_sent <= bz_sent + 1;
        end else begin
            bif.binaryzation_datav_i <= 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or a frame completion
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.pixel_datav_o) begin
                if (exp_px.size() == 0) begin
                    check_output("unexpected_pixel", 32'(bif.pixel_data_o), 32'hFFFF_FFFF);
                end else begin
                    check_output("pixel_data", 32'(bif.pixel_data_o), 32'(exp_px.pop_front()));
                end
            end else begin
                check_output("pixel_gap_zero", 32'(bif.pixel_data_o), 32'd0);
            end
            if (bif.frame_done_o) begin
                if (exp_done.size() == 0) begin
                    check_output("unexpected_done", 32'(bif.frame_cnt_o), 32'hFFFF_FFFF);
                end else begin
                    check_output("frame_cnt_at_done", 32'(bif.frame_cnt_o), 32'(exp_done.pop_front()));
                    check_output("pixels_left_at_done", 32'(exp_px.size()), 32'd0);
                end
                done_seen++;
            end
            if (bif.busy_o) begin
                check_output("threshold_held", 32'(bif.threshold_o), 32'(exp_thr));
            end
        end
    end

    // Runs one frame. mode: 0 continuous counting data, 1 toggling valid, 2 random.
    // kill_at/kill_kind: abandon after that many accepts (0 abort, 1 reset), -1 none.
    task automatic apply_stimulus(input logic [7:0] thr, input int mode, input int kill_at,
                                  input int kill_kind, input int restart_at, input int cfg_at,
                                  input int bz_lim);
        int  accepted = 0;
        int  ready_cycles = 0;
        int  guard = 0;
        int  waitc = 0;
        int  seen0;
        bit  restarted = 0;
        logic [7:0] d;
        bz_base  = bz_sent;
        bz_limit = bz_lim;
        @(negedge clk);
        bif.start_i         = 1'b1;
        bif.threshold_cfg_i = thr;
        @(negedge clk);
        bif.start_i = 1'b0;
        exp_thr     = thr;
        check_output("busy_after_start", 32'(bif.busy_o), 32'd1);
        check_output("timeout_clear_after_start", 32'(bif.timeout_o), 32'd0);
        while (accepted < N && guard < 400) begin
            if (kill_at == accepted) begin
                bif.src_valid_i = 1'b0;
                if (kill_kind == 0) begin
                    bif.abort_i = 1'b1;
                    @(negedge clk);
                    bif.abort_i = 1'b0;
                    check_output("abort_idle", 32'(bif.busy_o), 32'd0);
                    check_output("abort_frame_cnt", 32'(bif.frame_cnt_o), 32'(exp_frames));
                    check_output("abort_no_pixel", 32'(bif.pixel_datav_o), 32'd0);
                    check_output("abort_thr_kept", 32'(bif.threshold_o), 32'(thr));
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                    check_output("reset_busy", 32'(bif.busy_o), 32'd0);
                    check_output("reset_ready", 32'(bif.src_ready_o), 32'd0);
                    check_output("reset_datav", 32'(bif.pixel_datav_o), 32'd0);
                    check_output("reset_data", 32'(bif.pixel_data_o), 32'd0);
                    check_output("reset_threshold", 32'(bif.threshold_o), 32'd0);
                    check_output("reset_done", 32'(bif.frame_done_o), 32'd0);
                    check_output("reset_frame_cnt", 32'(bif.frame_cnt_o), 32'd0);
                    exp_px.delete();
                    exp_done.delete();
                    exp_frames = 16'd0;
                    exp_thr    = 8'd0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                return;
            end
            if (accepted == restart_at && !restarted) begin
                restarted           = 1;
                bif.start_i         = 1'b1;
                bif.threshold_cfg_i = 8'd77;
            end else begin
                bif.start_i         = 1'b0;
                bif.threshold_cfg_i = (cfg_at >= 0 && accepted >= cfg_at) ? 8'd200 : thr;
            end
            d = (mode == 0) ? 8'(8'h10 + accepted) : 8'($urandom);
            bif.src_data_i  = d;
            bif.src_valid_i = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            if (bif.src_ready_o) ready_cycles++;
            if (bif.src_valid_i && bif.src_ready_o) begin
                exp_px.push_back(d);
                accepted++;
            end
            guard++;
            @(negedge clk);
        end
        bif.src_valid_i = 1'b0;
        bif.start_i     = 1'b0;
        check_output("ready_low_after_last", 32'(bif.src_ready_o), 32'd0);
        if (mode == 0) begin
            check_output("ready_cycles", 32'(ready_cycles), N);
        end
        if (bz_lim >= N) begin
            exp_done.push_back(exp_frames);
            seen0 = done_seen;
            while (done_seen == seen0 && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            check_output("done_within_bound", 32'(done_seen - seen0), 32'd1);
            exp_frames = exp_frames + 16'd1;
            @(negedge clk);
            check_output("frame_cnt_after", 32'(bif.frame_cnt_o), 32'(exp_frames));
            check_output("idle_after_done", 32'(bif.busy_o), 32'd0);
        end else begin
`ifdef BINZ_DRAIN_TIMEOUT_EN
            while (!bif.timeout_o && waitc < 100) begin
                @(negedge clk);
                waitc++;
            end
            check_output("timeout_set", 32'(bif.timeout_o), 32'd1);
            check_output("timeout_latency_ok", 32'(waitc >= DT - 4 && waitc <= DT + 4), 32'd1);
            check_output("timeout_idle", 32'(bif.busy_o), 32'd0);
            check_output("timeout_frame_cnt", 32'(bif.frame_cnt_o), 32'(exp_frames));
            @(negedge clk);
            check_output("timeout_sticky", 32'(bif.timeout_o), 32'd1);
`else
            repeat (40) @(negedge clk);
            check_output("drain_stalls_busy", 32'(bif.busy_o), 32'd1);
            check_output("no_timeout_flag", 32'(bif.timeout_o), 32'd0);
            check_output("stall_frame_cnt", 32'(bif.frame_cnt_o), 32'(exp_frames));
            bif.abort_i = 1'b1;
            @(negedge clk);
            bif.abort_i = 1'b0;
            check_output("abort_from_drain", 32'(bif.busy_o), 32'd0);
`endif
        end
    endtask

    // Main sequence
    initial begin
        rst_n                = 1'b0;
        bif.start_i          = 1'b0;
        bif.abort_i          = 1'b0;
        bif.threshold_cfg_i  = 8'd0;
        bif.src_valid_i      = 1'b0;
        bif.src_data_i       = 8'd0;
        repeat (3) @(negedge clk);
        check_output("por_busy", 32'(bif.busy_o), 32'd0);
        check_output("por_frame_cnt", 32'(bif.frame_cnt_o), 32'd0);
        check_output("por_threshold", 32'(bif.threshold_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus(8'd128, 0, 3, 1, -1, -1, N);
        apply_stimulus(8'd128, 0, -1, 0, -1, -1, N);
        apply_stimulus(8'd128, 1, -1, 0, -1, -1, N);
        apply_stimulus(8'd128, 2, -1, 0, -1, 3, N);
        apply_stimulus(8'd200, 2, -1, 0, -1, -1, N);
        apply_stimulus(8'd128, 0, 5, 0, -1, -1, N);
        apply_stimulus(8'd90, 2, -1, 0, 3, -1, N);

        @(negedge clk);
        bif.start_i = 1'b1;
        bif.abort_i = 1'b1;
        @(negedge clk);
        bif.start_i = 1'b0;
        bif.abort_i = 1'b0;
        check_output("abort_beats_start", 32'(bif.busy_o), 32'd0);

        apply_stimulus(8'd128, 0, -1, 0, -1, -1, 6);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'($urandom), 2, -1, 0, -1, -1, N);
        end

        repeat (3) @(negedge clk);
        check_output("px_queue_empty_end", 32'(exp_px.size()), 32'd0);
        check_output("done_queue_empty_end", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
